// File: rtl/door_flash_bank.sv
// Bank of independent door-open LED flashers sharing one prescaler tick.
// Define DOOR_FLASH_RETRIGGER_EN to let a trigger during FLASH restart the sequence.

module door_flash_bank #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned FLASH_COUNT = 20,
    parameter int unsigned TICK_DIV    = 20_000_000
) (
    input  logic                clk_40MHz,
    input  logic                reset,
    input  logic [CHANNELS-1:0] trigger,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done
);

    localparam int unsigned CntW = $clog2(FLASH_COUNT + 1);
    localparam int unsigned DivW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {StIdle, StArmed, StFlash} state_e;

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic            tick;

    always_comb begin
        tick      = (div_cnt_q == DivW'(TICK_DIV - 1));
        div_cnt_d = tick ? '0 : div_cnt_q + DivW'(1);
    end

    always_ff @(posedge clk_40MHz) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        state_e          state_q, state_d;
        logic [CntW-1:0] count_q, count_d;
        logic            led_q, led_d;
        logic            busy_q;
        logic            done_q, done_d;
`ifdef DOOR_FLASH_RETRIGGER_EN
        logic            pending_q, pending_d;
`endif

        always_comb begin
            state_d = state_q;
            count_d = count_q;
            led_d   = led_q;
            done_d  = 1'b0;
`ifdef DOOR_FLASH_RETRIGGER_EN
            pending_d = pending_q;
`endif
            unique case (state_q)
                StIdle: begin
                    if (trigger[i]) begin
                        state_d = StArmed;
                    end
                end
                StArmed: begin
                    if (tick) begin
                        led_d   = 1'b1;
                        count_d = CntW'(FLASH_COUNT);
                        state_d = StFlash;
                    end
                end
                StFlash: begin
                    if (tick) begin
                        if (count_q > CntW'(1)) begin
                            count_d = count_q - CntW'(1);
                            led_d   = ~led_q;
`ifdef DOOR_FLASH_RETRIGGER_EN
                            // A trigger landing on this tick waits for the next one
                            if (pending_q) begin
                                led_d     = 1'b1;
                                count_d   = CntW'(FLASH_COUNT);
                                pending_d = trigger[i];
                            end
`endif
                        end else begin
                            count_d = '0;
                            led_d   = 1'b0;
                            done_d  = 1'b1;
                            state_d = StIdle;
`ifdef DOOR_FLASH_RETRIGGER_EN
                            if (pending_q || trigger[i]) begin
                                state_d = StArmed;
                            end
                            pending_d = 1'b0;
`endif
                        end
                    end else begin
`ifdef DOOR_FLASH_RETRIGGER_EN
                        if (trigger[i]) begin
                            pending_d = 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        always_ff @(posedge clk_40MHz) begin
            if (reset) begin
                state_q <= StIdle;
                count_q <= '0;
                led_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                count_q <= count_d;
                led_q   <= led_d;
                busy_q  <= (state_d != StIdle);
                done_q  <= done_d;
            end
        end

`ifdef DOOR_FLASH_RETRIGGER_EN
        always_ff @(posedge clk_40MHz) begin
            if (reset) begin
                pending_q <= 1'b0;
            end else begin
                pending_q <= pending_d;
            end
        end
`endif

        assign led[i]  = led_q;
        assign busy[i] = busy_q;
        assign done[i] = done_q;
    end

endmodule
